// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: FSM, ALU decoder, retired-instruction counter.
// Optional illegal-opcode trap state enabled by defining ILLEGAL_TRAP_EN.

module aludec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  logic rtype_sub;

  assign rtype_sub = funct7b5 & opb5;

  // Map ALUOp and function fields onto an ALU operation
  always_comb begin
    alucontrol = 3'b000;
    unique case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      default: begin
        unique case (funct3)
          3'b000:  alucontrol = rtype_sub ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end

endmodule

module multicycle_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } state_t;

  state_t state, state_n;

  logic       is_lw;
  logic       is_sw;
  logic       is_r;
  logic       is_i;
  logic       is_beq;
  logic       is_jal;
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;
  logic       retire;

  assign is_lw  = (op == 7'b0000011);
  assign is_sw  = (op == 7'b0100011);
  assign is_r   = (op == 7'b0110011);
  assign is_i   = (op == 7'b0010011);
  assign is_beq = (op == 7'b1100011);
  assign is_jal = (op == 7'b1101111);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_n;
  end

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:    if (mem_ready) state_n = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_lw:   state_n = MEMADR;
          is_sw:   state_n = MEMADR;
          is_r:    state_n = EXECUTER;
          is_i:    state_n = EXECUTEI;
          is_beq:  state_n = BEQ;
          is_jal:  state_n = JAL;
`ifdef ILLEGAL_TRAP_EN
          default: state_n = TRAP;
`else
          default: state_n = FETCH;
`endif
        endcase
      end
      MEMADR:   state_n = is_lw ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (mem_ready) state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BEQ:      state_n = FETCH;
      JAL:      state_n = ALUWB;
      TRAP:     state_n = TRAP;
      default:  state_n = FETCH;
    endcase
  end

  // Per-state datapath selects and enables
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    aluop     = 2'b00;
    unique case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pcupdate  = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign PCWrite = pcupdate | (branch & Zero);

  // Immediate format depends only on the opcode
  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      is_sw:   ImmSrc = 2'b01;
      is_beq:  ImmSrc = 2'b10;
      is_jal:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  aludec u_aludec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (aluop),
    .alucontrol (ALUControl)
  );

  assign retire = (state == MEMWB) |
                  (state == ALUWB) |
                  (state == BEQ) |
                  ((state == MEMWRITE) & mem_ready);

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Uses a 3-bit instret so counter wrap is reachable.

module tb_multicycle_controller;

  localparam int W = 3;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {mem_req,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,ALUSrcA,ALUSrcB,ResultSrc}
  localparam logic [11:0] C_FETCH_R = 12'b1011_0000_1010;
  localparam logic [11:0] C_FETCH_W = 12'b1000_0000_1010;
  localparam logic [11:0] C_DECODE  = 12'b0000_0001_0100;
  localparam logic [11:0] C_MEMADR  = 12'b0000_0010_0100;
  localparam logic [11:0] C_MEMRD   = 12'b1100_0000_0000;
  localparam logic [11:0] C_MEMWB   = 12'b0000_1000_0001;
  localparam logic [11:0] C_MEMWR   = 12'b1100_0100_0000;
  localparam logic [11:0] C_EXER    = 12'b0000_0010_0000;
  localparam logic [11:0] C_EXEI    = 12'b0000_0010_0100;
  localparam logic [11:0] C_ALUWB   = 12'b0000_1000_0000;
  localparam logic [11:0] C_BEQ_T   = 12'b0001_0010_0000;
  localparam logic [11:0] C_BEQ_N   = 12'b0000_0010_0000;
  localparam logic [11:0] C_JAL     = 12'b0001_0001_1000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [6:0]   op;
  logic [2:0]   funct3;
  logic         funct7b5;
  logic         Zero;
  logic         mem_ready;
  logic         mem_req;
  logic         AdrSrc;
  logic         IRWrite;
  logic         PCWrite;
  logic         RegWrite;
  logic         MemWrite;
  logic [1:0]   ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [1:0]   ImmSrc;
  logic [2:0]   ALUControl;
  logic [W-1:0] instret;
  logic         illegal;
  logic [11:0]  ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                ALUSrcA, ALUSrcB, ResultSrc};

  multicycle_controller #(.INSTRET_W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .instret    (instret),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    op        = OP_LW;
    funct3    = 3'b010;
    funct7b5  = 1'b0;
    Zero      = 1'b0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_ctl", 32'(ctl), 32'(C_FETCH_W));
    chk("rst_instret", 32'(instret), 0);
    chk("rst_illegal", 32'(illegal), 0);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    settle();

    // lw, 5 cycles
    chk("lw_c0", 32'(ctl), 32'(C_FETCH_R));
    chk("lw_imm", 32'(ImmSrc), 0);
    cyc();
    chk("lw_c1", 32'(ctl), 32'(C_DECODE));
    cyc();
    chk("lw_c2", 32'(ctl), 32'(C_MEMADR));
    chk("lw_alu", 32'(ALUControl), 0);
    cyc();
    chk("lw_c3", 32'(ctl), 32'(C_MEMRD));
    cyc();
    chk("lw_c4", 32'(ctl), 32'(C_MEMWB));
    chk("lw_ir_pre", 32'(instret), 0);
    cyc();
    chk("lw_ir_post", 32'(instret), 1);

    // sw, memory stalls 3 cycles in MEMWRITE
    op = OP_SW;
    settle();
    chk("sw_c0", 32'(ctl), 32'(C_FETCH_R));
    chk("sw_imm", 32'(ImmSrc), 1);
    cyc();
    chk("sw_c1", 32'(ctl), 32'(C_DECODE));
    cyc();
    mem_ready = 1'b0;
    settle();
    chk("sw_c2", 32'(ctl), 32'(C_MEMADR));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sw_wait", 32'(ctl), 32'(C_MEMWR));
    end
    mem_ready = 1'b1;
    settle();
    chk("sw_commit", 32'(ctl), 32'(C_MEMWR));
    chk("sw_ir_pre", 32'(instret), 1);
    cyc();
    chk("sw_done", 32'(ctl), 32'(C_FETCH_R));
    chk("sw_ir_post", 32'(instret), 2);

    // add
    op = OP_R;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    cyc();
    cyc();
    chk("add_exe", 32'(ctl), 32'(C_EXER));
    chk("add_alu", 32'(ALUControl), 0);
    cyc();
    chk("add_wb", 32'(ctl), 32'(C_ALUWB));
    cyc();
    chk("add_ir", 32'(instret), 3);

    // sub
    funct7b5 = 1'b1;
    cyc();
    cyc();
    chk("sub_exe", 32'(ctl), 32'(C_EXER));
    chk("sub_alu", 32'(ALUControl), 1);
    cyc();
    cyc();
    chk("sub_ir", 32'(instret), 4);

    // addi with instr[30] set must still add
    op = OP_I;
    settle();
    cyc();
    cyc();
    chk("addi_exe", 32'(ctl), 32'(C_EXEI));
    chk("addi_alu", 32'(ALUControl), 0);
    cyc();
    chk("addi_wb", 32'(ctl), 32'(C_ALUWB));
    cyc();
    chk("addi_ir", 32'(instret), 5);

    // beq taken
    op = OP_BEQ;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    Zero = 1'b1;
    settle();
    chk("beq_imm", 32'(ImmSrc), 2);
    cyc();
    cyc();
    chk("beqt_ctl", 32'(ctl), 32'(C_BEQ_T));
    chk("beqt_alu", 32'(ALUControl), 1);
    cyc();
    chk("beqt_fetch", 32'(ctl), 32'(C_FETCH_R));
    chk("beqt_ir", 32'(instret), 6);

    // beq not taken
    Zero = 1'b0;
    cyc();
    cyc();
    chk("beqn_ctl", 32'(ctl), 32'(C_BEQ_N));
    chk("beqn_alu", 32'(ALUControl), 1);
    cyc();
    chk("beqn_ir", 32'(instret), 7);

    // jal; instret wraps 7 -> 0
    op = OP_JAL;
    settle();
    chk("jal_imm", 32'(ImmSrc), 3);
    cyc();
    cyc();
    chk("jal_ctl", 32'(ctl), 32'(C_JAL));
    chk("jal_alu", 32'(ALUControl), 0);
    cyc();
    chk("jal_wb", 32'(ctl), 32'(C_ALUWB));
    cyc();
    chk("jal_wrap", 32'(instret), 0);

    // one more addi
    op = OP_I;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("addi2_ir", 32'(instret), 1);

    // illegal opcode
    op = OP_BAD;
    cyc();
    chk("bad_dec", 32'(ctl), 32'(C_DECODE));
    cyc();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      chk("trap_ill", 32'(illegal), 1);
      chk("trap_ctl", 32'(ctl), 0);
      cyc();
    end
    chk("trap_ir", 32'(instret), 1);
    reset_n = 1'b0;
    settle();
    reset_n = 1'b1;
    settle();
    chk("trap_rst", 32'(illegal), 0);
`else
    chk("bad_fetch", 32'(ctl), 32'(C_FETCH_R));
    chk("bad_ill", 32'(illegal), 0);
    cyc();
    chk("bad_ir", 32'(instret), 1);
    op = OP_LW;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("lw2_ir", 32'(instret), 2);
`endif

    // lw with fetch stall, then reset in MEMREAD stall
    op = OP_LW;
    mem_ready = 1'b0;
    settle();
    chk("fs_c0", 32'(ctl), 32'(C_FETCH_W));
    cyc();
    chk("fs_c1", 32'(ctl), 32'(C_FETCH_W));
    mem_ready = 1'b1;
    settle();
    chk("fs_go", 32'(ctl), 32'(C_FETCH_R));
    cyc();
    chk("fs_dec", 32'(ctl), 32'(C_DECODE));
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("mr_wait0", 32'(ctl), 32'(C_MEMRD));
    cyc();
    chk("mr_wait1", 32'(ctl), 32'(C_MEMRD));
    reset_n = 1'b0;
    settle();
    chk("mr_rst_ctl", 32'(ctl), 32'(C_FETCH_W));
    chk("mr_rst_ir", 32'(instret), 0);
    cyc();
    chk("mr_rst_rw", 32'({RegWrite, MemWrite}), 0);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    settle();
    chk("mr_rel", 32'(ctl), 32'(C_FETCH_R));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
